uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  UART receive controller for the RX path. Detects the start bit and drives the
//  enable of the downstream edge/bit counter. Oversamples RX_IN against the returned
//  edge_cnt, deserialises the frame LSB-first and checks start, parity and stop.
//  Delivers P_DATA with a one-cycle data_valid pulse to the RX sync/register-file side.
// PARAMETERS
//  DATA_WIDTH      8  payload bits per frame
//  PRESCALE_WIDTH  6  width of Prescale/edge_cnt; legal Prescale = 8,16,32
// PORTS
//  CLK         in   1       RX oversampling clock (Prescale x baud)
//  RST         in   1       async reset, active-low
//  RX_IN       in   1       serial line, idle high; already synchronised
//  Prescale    in   PW      oversampling ratio
//  PAR_EN      in   1       1 = parity bit present
//  PAR_TYP     in   1       0 = even, 1 = odd
//  edge_cnt    in   PW      from edge counter; 0..Prescale-1, wraps to 0
//  cnt_enable  out  1       enable to edge counter
//  P_DATA      out  DW      received payload
//  data_valid  out  1       1-cycle pulse, good frame
//  par_err     out  1       1-cycle pulse, parity mismatch
//  stp_err     out  1       1-cycle pulse, stop bit sampled low
// BEHAVIOUR
//  Reset: state=IDLE; cnt_enable, data_valid, par_err, stp_err = 0; P_DATA = 0; shift reg/index = 0.
//  Prescale, PAR_EN, PAR_TYP latched on IDLE->START; mid-frame changes ignored.
//  bit_end = (edge_cnt == Prescale_q-1). mid = Prescale_q/2.
//  Sample: RX_IN captured at edge_cnt = mid-1, mid, mid+1; bit value = 2-of-3 majority, valid at bit_end.
//  FSM: IDLE -> START on RX_IN==0; cnt_enable rises in the same edge.
//   START: at bit_end, sample==1 -> IDLE (glitch, no flags, cnt_enable=0); else -> DATA.
//   DATA: at each bit_end shift the sample into bit[idx], idx++; at idx==DW-1 -> PARITY if PAR_EN, else STOP.
//   PARITY: at bit_end, par_fail = sample ^ (^shift ^ PAR_TYP); -> STOP.
//   STOP: at bit_end, stp_fail = ~sample; -> DONE.
//   DONE (1 cycle): cnt_enable=0 (counter clears).
//     No fail: P_DATA <= shift and data_valid=1. Otherwise P_DATA holds, par_err/stp_err pulse as applicable (both allowed).
//     Next state: RX_IN==0 -> START (back-to-back), else IDLE.
//  Latency: data_valid 1 cycle after the stop-bit bit_end.
//  Line low in IDLE after an error: treated as a new start (break is not detected).
//  Async reset mid-frame: immediate return to reset values; partial frame discarded.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: 3-sample majority as above.
//  Not defined: single sample at edge_cnt == mid, no vote registers; timing otherwise identical.
// STRUCTURE
//  uart_rx_pkg: state encodings (IDLE, START, DATA, PARITY, STOP, DONE), PRESCALE_MIN=8.
//  Sub-module rx_data_sampling: edge_cnt/Prescale/RX_IN -> sampled_bit (holds macro logic).
//  FSM, deserialiser and checkers stay in uart_rx_ctrl.
// TESTING
//  Prescale=8, PAR_EN=0, send 0xA5 -> P_DATA=0xA5, data_valid 1 cycle, no err pulses.
//  Prescale=16, PAR_EN=1 even, 0x3C with parity=1 (wrong) -> par_err pulse, P_DATA keeps old value.
//  Prescale=32, stop bit forced 0 for frame 0x81 -> stp_err pulse, no data_valid.
//  3-cycle low glitch in IDLE -> START aborts at bit_end to IDLE, cnt_enable low, no outputs.
//  Two back-to-back frames 0x11, 0xEE, no idle gap -> two data_valid pulses with correct data.
//  1 sample of the 3 flipped at mid on a data bit (macro on) -> byte correct; RST low mid-DATA -> all outputs 0, IDLE.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
//  - FSM state encodings (plain logic constants for legacy tools).
//  - PRESCALE_MIN: smallest legal oversampling ratio; also the reset value of
//    the latched prescale so bit_end decoding is sane before the first frame.
//  - majority3: 2-of-3 vote used when UART_RX_MAJORITY_EN is defined.
package uart_rx_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int unsigned PRESCALE_MIN = 8;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/rx_data_sampling.sv
// Oversampling bit sampler for the UART receiver.
// Build option: UART_RX_MAJORITY_EN
//   defined     - RX line captured at edge_cnt = mid-1, mid, mid+1; bit = 2-of-3 vote
//   not defined - single capture at edge_cnt = mid
//   where mid = prescale/2. sampled_bit is stable by bit_end (edge_cnt = prescale-1).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   rx_in        synchronised serial line
//   prescale     latched oversampling ratio
//   edge_cnt     position within the current bit period
//   sampled_bit  recovered bit value
module rx_data_sampling
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      sampled_bit
);

  logic [PRESCALE_WIDTH-1:0] mid;
  assign mid = prescale >> 1;

`ifdef UART_RX_MAJORITY_EN
  logic [PRESCALE_WIDTH-1:0] mid_lo;
  logic [PRESCALE_WIDTH-1:0] mid_hi;
  logic [2:0]                votes_q;

  assign mid_lo = mid - PRESCALE_WIDTH'(1);
  assign mid_hi = mid + PRESCALE_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      votes_q <= 3'b000;
    end else begin
      if (edge_cnt == mid_lo) votes_q[0] <= rx_in;
      if (edge_cnt == mid)    votes_q[1] <= rx_in;
      if (edge_cnt == mid_hi) votes_q[2] <= rx_in;
    end
  end

  assign sampled_bit = majority3(votes_q);
`else
  logic sample_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
    end else if (edge_cnt == mid) begin
      sample_q <= rx_in;
    end
  end

  assign sampled_bit = sample_q;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, edge-counter enable, LSB-first
// deserialisation, parity and stop checking, one-cycle result pulses.
// Build option: UART_RX_MAJORITY_EN selects 3-sample majority in rx_data_sampling.
// Ports:
//   CLK, RST     oversampling clock, async active-low reset
//   RX_IN        serial line (idle high, already synchronised)
//   Prescale     oversampling ratio (8/16/32), latched at frame start
//   PAR_EN       parity bit present; PAR_TYP 0 = even, 1 = odd (latched)
//   edge_cnt     returned edge counter value, 0..Prescale-1
//   cnt_enable   enable to the edge counter
//   P_DATA       last good payload
//   data_valid   1-cycle pulse, good frame
//   par_err      1-cycle pulse, parity mismatch
//   stp_err      1-cycle pulse, stop bit low
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      cnt_enable,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int unsigned IdxW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  logic [2:0]                state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic                      par_fail_q, par_fail_d;
  logic                      cnt_enable_q, cnt_enable_d;
  logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
  logic                      data_valid_q, data_valid_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;

  logic bit_end;
  logic sampled_bit;
  logic stp_fail;

  assign bit_end = (edge_cnt == (prescale_q - PRESCALE_WIDTH'(1)));

  rx_data_sampling #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampling (
    .clk        (CLK),
    .rst_n      (RST),
    .rx_in      (RX_IN),
    .prescale   (prescale_q),
    .edge_cnt   (edge_cnt),
    .sampled_bit(sampled_bit)
  );

  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    par_fail_d   = par_fail_q;
    cnt_enable_d = cnt_enable_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    stp_fail     = 1'b0;

    case (state_q)
      // IDLE and DONE both accept a falling line as a new start bit; frame
      // configuration is captured here so mid-frame input changes are ignored.
      IDLE, DONE: begin
        if (!RX_IN) begin
          state_d      = START;
          cnt_enable_d = 1'b1;
          prescale_d   = Prescale;
          par_en_d     = PAR_EN;
          par_typ_d    = PAR_TYP;
          shift_d      = '0;
          idx_d        = '0;
          par_fail_d   = 1'b0;
        end else begin
          state_d      = IDLE;
          cnt_enable_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          if (sampled_bit) begin
            // Start bit did not hold low through mid-bit: treat as a glitch.
            state_d      = IDLE;
            cnt_enable_d = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d[idx_q] = sampled_bit;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_fail_d = sampled_bit ^ (^shift_q ^ par_typ_q);
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          stp_fail     = ~sampled_bit;
          // Result pulses are registered here so they are high exactly
          // during the single DONE cycle, with P_DATA already updated.
          if (!par_fail_q && !stp_fail) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end else begin
            par_err_d = par_fail_q;
            stp_err_d = stp_fail;
          end
          cnt_enable_d = 1'b0;
          state_d      = DONE;
        end
      end
      default: begin
        state_d      = IDLE;
        cnt_enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      prescale_q   <= PRESCALE_WIDTH'(PRESCALE_MIN);
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      shift_q      <= '0;
      idx_q        <= '0;
      par_fail_q   <= 1'b0;
      cnt_enable_q <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      par_fail_q   <= par_fail_d;
      cnt_enable_q <= cnt_enable_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign cnt_enable = cnt_enable_q;
  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. Includes a behavioural edge counter.
// Expected result pulses are queued when a frame is driven and compared by a
// monitor whenever the DUT raises data_valid/par_err/stp_err.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] prescale = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic          cnt_enable;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] last_good = '0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(
    .DATA_WIDTH    (DW),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .Prescale  (prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .edge_cnt  (edge_cnt),
    .cnt_enable(cnt_enable),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  // Downstream edge counter: counts 0..prescale-1 while enabled, else clears.
  always @(posedge CLK or negedge RST) begin
    if (!RST)                            edge_cnt <= '0;
    else if (!cnt_enable)                edge_cnt <= '0;
    else if (edge_cnt == prescale - 6'd1) edge_cnt <= '0;
    else                                 edge_cnt <= edge_cnt + 6'd1;
  end

  // Scoreboard monitor.
  always @(negedge CLK) begin
    if (RST && (data_valid || par_err || stp_err)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b P_DATA=%h, required no pulse",
                 data_valid, par_err, stp_err, P_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        if ({data_valid, par_err, stp_err, P_DATA} !== {mon_e.dv, mon_e.pe, mon_e.se, mon_e.data})
        begin
          n_err++;
          $display("FAIL frame_result: got dv=%0b pe=%0b se=%0b P_DATA=%h, required dv=%0b pe=%0b se=%0b P_DATA=%h",
                   data_valid, par_err, stp_err, P_DATA, mon_e.dv, mon_e.pe, mon_e.se, mon_e.data);
        end
      end
    end
  end

  // One bit period; the line is inverted for the single cycle flip_c.
  task automatic drive_bit(input logic v, input int flip_c);
    for (int c = 0; c < int'(prescale); c++) begin
      RX_IN = (c == flip_c) ? ~v : v;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic par_en, input logic par_typ,
                            input logic par_wrong, input logic stop_v,
                            input int flip_bit, input int flip_c);
    logic pe;
    logic se;
    PAR_EN  = par_en;
    PAR_TYP = par_typ;
    pe = par_en && par_wrong;
    se = !stop_v;
    if (!pe && !se) begin
      exp_q.push_back('{dv: 1'b1, pe: 1'b0, se: 1'b0, data: data});
      last_good = data;
    end else begin
      exp_q.push_back('{dv: 1'b0, pe: pe, se: se, data: last_good});
    end
    drive_bit(1'b0, -1);
    for (int i = 0; i < DW; i++) drive_bit(data[i], (i == flip_bit) ? flip_c : -1);
    if (par_en) drive_bit((^data) ^ par_typ ^ par_wrong, -1);
    drive_bit(stop_v, -1);
    RX_IN = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if (cnt_enable !== 1'b0) begin
      n_err++; $display("FAIL reset_cnt_enable: got %b, required 0", cnt_enable);
    end
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_data_valid: got %b, required 0", data_valid);
    end
    n_cmp++;
    if (par_err !== 1'b0) begin
      n_err++; $display("FAIL reset_par_err: got %b, required 0", par_err);
    end
    n_cmp++;
    if (stp_err !== 1'b0) begin
      n_err++; $display("FAIL reset_stp_err: got %b, required 0", stp_err);
    end
    n_cmp++;
    if (P_DATA !== 8'h00) begin
      n_err++; $display("FAIL reset_p_data: got %h, required 00", P_DATA);
    end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (cnt_enable !== 1'b0) begin
      n_err++; $display("FAIL idle_cnt_enable: got %b, required 0", cnt_enable);
    end
  endtask

  task automatic test_basic;
    prescale = 6'd8;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_early_valid: got %b, required 0", data_valid);
    end
    @(posedge CLK);
    #1;
    n_cmp++;
    if (data_valid !== 1'b1) begin
      n_err++; $display("FAIL basic_latency: got %b, required 1", data_valid);
    end
    n_cmp++;
    if (cnt_enable !== 1'b0) begin
      n_err++; $display("FAIL basic_done_cnt_enable: got %b, required 0", cnt_enable);
    end
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL basic_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_parity;
    prescale = 6'd16;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL parity_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_stop_err;
    prescale = 6'd32;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (cnt_enable !== 1'b0) begin
      n_err++; $display("FAIL stop_err_idle: got cnt_enable=%b, required 0", cnt_enable);
    end
    prescale = 6'd8;
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1);
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL stop_err_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_glitch;
    prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    RX_IN = 1'b1;
    n_cmp++;
    if (cnt_enable !== 1'b1) begin
      n_err++; $display("FAIL glitch_start: got cnt_enable=%b, required 1", cnt_enable);
    end
    repeat (8) @(posedge CLK);
    #1;
    n_cmp++;
    if (cnt_enable !== 1'b0) begin
      n_err++; $display("FAIL glitch_abort: got cnt_enable=%b, required 0", cnt_enable);
    end
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if ({data_valid, par_err, stp_err} !== 3'b000) begin
      n_err++; $display("FAIL glitch_outputs: got %b, required 000", {data_valid, par_err, stp_err});
    end
  endtask

  task automatic test_back_to_back;
    prescale = 6'd8;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_majority;
    int flip_c;
    prescale = 6'd16;
`ifdef UART_RX_MAJORITY_EN
    flip_c = 9;   // cycle whose capture edge sees edge_cnt == mid
`else
    flip_c = 10;  // edge_cnt == mid+1, outside the single sample point
`endif
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 3, flip_c);
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL majority_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    prescale = 6'd8;
    PAR_EN = 1'b0;
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({cnt_enable, data_valid, par_err, stp_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_flags: got %b, required 0000",
               {cnt_enable, data_valid, par_err, stp_err});
    end
    n_cmp++;
    if (P_DATA !== 8'h00) begin
      n_err++; $display("FAIL midreset_p_data: got %h, required 00", P_DATA);
    end
    RX_IN = 1'b1;
    last_good = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL midreset_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_majority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
